// File: rtl/st7066u_update_arbiter_if.sv
// Handshake bundle between the update-event sources / LCD controller and the
// ST7066U update arbiter.
interface st7066u_update_arbiter_if #(
    parameter int N_SRC = 4
);
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] i_src_pulse;
    logic             i_wr;
    logic             i_ena;
    logic             i_clr_ovr;
    logic             o_update_pulse;
    logic [SW-1:0]    o_src_id;
    logic [N_SRC-1:0] o_pending;
    logic             o_overrun;

    modport master (
        output i_src_pulse, i_wr, i_ena, i_clr_ovr,
        input  o_update_pulse, o_src_id, o_pending, o_overrun
    );

    modport slave (
        input  i_src_pulse, i_wr, i_ena, i_clr_ovr,
        output o_update_pulse, o_src_id, o_pending, o_overrun
    );
endinterface

// File: rtl/st7066u_update_arbiter.sv
// ST7066U update arbiter: coalesces one-cycle update events from several
// sources into a single held request towards the LCD controller, enforces a
// holdoff after each acknowledge and flags events lost by coalescing.
//
// state  | meaning
// S_IDLE | free; any event (pending or new) is captured into a request
// S_REQ  | request held, waiting for the controller acknowledge
// S_HOLD | post-acknowledge holdoff, counter runs down to 0
module st7066u_update_arbiter #(
    parameter int               N_SRC     = 4,
    parameter int               HOLDOFF   = 1000,
    parameter logic [N_SRC-1:0] RUN_MASK  = N_SRC'(4'b0001),
    parameter logic [N_SRC-1:0] EDIT_MASK = N_SRC'(4'b1110)
) (
    input logic                    i_clk,
    input logic                    i_rst,
    st7066u_update_arbiter_if.slave bus
);
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             req_q, req_d;
    logic [SW-1:0]    id_q, id_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic             ovr_q, ovr_d;

    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] hits;
    logic [N_SRC-1:0] events;
    logic [SW-1:0]    first_id;

    // Effective source mask, accepted pulses and the lowest-index event.
    always_comb begin
        mask     = bus.i_wr ? EDIT_MASK : RUN_MASK;
        hits     = bus.i_src_pulse & mask;
        events   = pend_q | hits;
        first_id = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (events[k]) first_id = SW'(k);
        end
    end

    // Next-state and next-output logic; pending bits accumulate unless consumed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        id_d    = id_q;
        pend_d  = (pend_q | hits) & mask;
        // A pulse landing on an already-pending bit is merged and lost; set beats clear.
        ovr_d   = (ovr_q & ~bus.i_clr_ovr) | (|(hits & pend_q));
        case (state_q)
            S_IDLE: begin
                req_d = 1'b0;
                if (|events) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    id_d    = first_id;
                    pend_d  = '0;
                end
            end
            S_REQ: begin
                if (bus.i_ena) begin
                    req_d = 1'b0;
                    if (HOLDOFF == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            id_q    <= '0;
            pend_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.o_update_pulse = req_q;
    assign bus.o_src_id       = id_q;
    assign bus.o_pending      = pend_q;
    assign bus.o_overrun      = ovr_q;
endmodule

// File: tb/tb_st7066u_update_arbiter.sv
// Bench for st7066u_update_arbiter: three instances (HOLDOFF 1000, 0, 3) share
// one stimulus stream; directed vectors plus a randomized run against a model.
module tb_st7066u_update_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src_pulse;
    logic       wr, ena, clr;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    st7066u_update_arbiter_if #(.N_SRC(4)) bus_a ();
    st7066u_update_arbiter_if #(.N_SRC(4)) bus_b ();
    st7066u_update_arbiter_if #(.N_SRC(4)) bus_c ();

    assign bus_a.i_src_pulse = src_pulse;
    assign bus_a.i_wr        = wr;
    assign bus_a.i_ena       = ena;
    assign bus_a.i_clr_ovr   = clr;
    assign bus_b.i_src_pulse = src_pulse;
    assign bus_b.i_wr        = wr;
    assign bus_b.i_ena       = ena;
    assign bus_b.i_clr_ovr   = clr;
    assign bus_c.i_src_pulse = src_pulse;
    assign bus_c.i_wr        = wr;
    assign bus_c.i_ena       = ena;
    assign bus_c.i_clr_ovr   = clr;

    st7066u_update_arbiter #(.N_SRC(4), .HOLDOFF(1000), .RUN_MASK(4'b0001), .EDIT_MASK(4'b1110))
        dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a.slave));
    st7066u_update_arbiter #(.N_SRC(4), .HOLDOFF(0), .RUN_MASK(4'b0001), .EDIT_MASK(4'b1110))
        dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b.slave));
    st7066u_update_arbiter #(.N_SRC(4), .HOLDOFF(3), .RUN_MASK(4'b0001), .EDIT_MASK(4'b1110))
        dut_c (.i_clk(clk), .i_rst(rst), .bus(bus_c.slave));

    // Reference model: request flag, captured id, pending set, overrun and
    // the absolute cycle at which each arbiter is free to capture again.
    int       hold_of[3] = '{1000, 0, 3};
    bit       m_req [3];
    bit [1:0] m_id  [3];
    bit [3:0] m_pend[3];
    bit       m_ovr [3];
    longint   m_rel [3];
    longint   gcyc = 0;

    function automatic bit [1:0] lowest(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic model_step();
        bit [3:0] mask, hits, ev;
        bit       novr;
        mask = wr ? 4'b1110 : 4'b0001;
        hits = src_pulse & mask;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_req[d] = 0; m_id[d] = 0; m_pend[d] = 0; m_ovr[d] = 0; m_rel[d] = 0;
            end else begin
                novr = (m_ovr[d] && !clr) || ((hits & m_pend[d]) != 0);
                if (!m_req[d] && gcyc >= m_rel[d]) begin
                    ev = m_pend[d] | hits;
                    if (ev != 0) begin
                        m_req[d] = 1;
                        m_id[d]  = lowest(ev);
                    end
                    m_pend[d] = 0;
                end else begin
                    m_pend[d] = (m_pend[d] | hits) & mask;
                    if (m_req[d] && ena) begin
                        m_req[d] = 0;
                        m_rel[d] = gcyc + 1 + hold_of[d];
                    end
                end
                m_ovr[d] = novr;
            end
        end
        gcyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit [3:0] p, input bit w, input bit e, input bit c);
        src_pulse = p; wr = w; ena = e; clr = c;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int get_out(input int d);
        case (d)
            0:       return int'({bus_a.o_update_pulse, bus_a.o_src_id, bus_a.o_pending, bus_a.o_overrun});
            1:       return int'({bus_b.o_update_pulse, bus_b.o_src_id, bus_b.o_pending, bus_b.o_overrun});
            default: return int'({bus_c.o_update_pulse, bus_c.o_src_id, bus_c.o_pending, bus_c.o_overrun});
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        drive(4'b0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit [3:0] p;
        bit       w, e, c;
        bit       x_req;
        bit [1:0] x_id;
        bit [3:0] x_pend;
        bit       x_ovr;
    } vec_t;

    vec_t vt[10];

    initial begin
        int early, bad_len, rises, min_gap, last_rise, run;
        bit prev;

        // Expected outputs of the HOLDOFF=1000 instance after each vector.
        vt[0] = '{4'b0100, 0, 0, 0, 0, 2'd0, 4'b0000, 0};
        vt[1] = '{4'b1010, 1, 0, 0, 1, 2'd1, 4'b0000, 0};
        vt[2] = '{4'b1000, 1, 0, 0, 1, 2'd1, 4'b1000, 0};
        vt[3] = '{4'b1000, 1, 0, 0, 1, 2'd1, 4'b1000, 1};
        vt[4] = '{4'b0000, 1, 0, 1, 1, 2'd1, 4'b1000, 0};
        vt[5] = '{4'b1000, 1, 0, 1, 1, 2'd1, 4'b1000, 1};
        vt[6] = '{4'b0000, 0, 0, 0, 1, 2'd1, 4'b0000, 1};
        vt[7] = '{4'b0000, 0, 1, 1, 0, 2'd1, 4'b0000, 0};
        vt[8] = '{4'b0001, 0, 0, 0, 0, 2'd1, 4'b0001, 0};
        vt[9] = '{4'b0000, 0, 1, 0, 0, 2'd1, 4'b0001, 0};

        do_reset();
        chk("reset_a", get_out(0), 0);
        chk("reset_b", get_out(1), 0);
        chk("reset_c", get_out(2), 0);

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].p, vt[i].w, vt[i].e, vt[i].c);
            tick();
            chk($sformatf("vec%0d_req", i),  int'(bus_a.o_update_pulse), int'(vt[i].x_req));
            chk($sformatf("vec%0d_id", i),   int'(bus_a.o_src_id),       int'(vt[i].x_id));
            chk($sformatf("vec%0d_pend", i), int'(bus_a.o_pending),      int'(vt[i].x_pend));
            chk($sformatf("vec%0d_ovr", i),  int'(bus_a.o_overrun),      int'(vt[i].x_ovr));
        end

        // Default holdoff timeline, with events coalescing during HOLD.
        do_reset();
        early = 0;
        for (int c = 0; c <= 1016; c++) begin
            drive((c == 10 || c == 515 || c == 600) ? 4'b0001 : 4'b0000, 0, (c == 15), (c == 700));
            tick();
            if (c < 10 || (c >= 15 && c < 1016)) early += int'(bus_a.o_update_pulse);
            if (c == 10) begin
                chk("lat_req", int'(bus_a.o_update_pulse), 1);
                chk("lat_id", int'(bus_a.o_src_id), 0);
            end
            if (c == 14) chk("req_held", int'(bus_a.o_update_pulse), 1);
            if (c == 15) chk("ack_drop", int'(bus_a.o_update_pulse), 0);
            if (c == 515) chk("hold_pend", int'(bus_a.o_pending), 1);
            if (c == 600) chk("hold_ovr", int'(bus_a.o_overrun), 1);
            if (c == 700) chk("clr_ovr", int'(bus_a.o_overrun), 0);
            if (c == 1016) begin
                chk("post_hold_req", int'(bus_a.o_update_pulse), 1);
                chk("post_hold_id", int'(bus_a.o_src_id), 0);
                chk("post_hold_pend", int'(bus_a.o_pending), 0);
            end
        end
        chk("holdoff_quiet", early, 0);

        // Reset in the middle of REQ with a pending bit.
        do_reset();
        drive(4'b0100, 1, 0, 0); tick();
        chk("mid_req_id", int'(bus_a.o_src_id), 2);
        drive(4'b0010, 1, 0, 0); tick();
        chk("mid_req_pend", int'(bus_a.o_pending), 2);
        rst = 1'b1; drive(4'b0, 1, 0, 0); tick(); rst = 1'b0;
        chk("rst_mid_req", get_out(0), 0);
        early = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            early += int'(bus_a.o_update_pulse) + int'(bus_a.o_pending);
        end
        chk("rst_quiet", early, 0);
        drive(4'b0100, 1, 0, 0); tick();
        chk("rst_new_req", int'(bus_a.o_update_pulse), 1);

        // HOLDOFF=0: back-to-back request after an acknowledge.
        do_reset();
        drive(4'b0010, 1, 0, 0); tick();
        chk("h0_req", int'(bus_b.o_update_pulse), 1);
        chk("h0_id", int'(bus_b.o_src_id), 1);
        drive(4'b0100, 1, 1, 0); tick();
        chk("h0_ack", int'(bus_b.o_update_pulse), 0);
        chk("h0_pend", int'(bus_b.o_pending), 4);
        drive(4'b0000, 1, 0, 0); tick();
        chk("h0_rereq", int'(bus_b.o_update_pulse), 1);
        chk("h0_reid", int'(bus_b.o_src_id), 2);

        // HOLDOFF=3, acknowledge held high, pulse every other cycle.
        do_reset();
        rises = 0; bad_len = 0; min_gap = 1000; last_rise = -1; run = 0; prev = 0;
        for (int c = 0; c < 80; c++) begin
            drive((c % 2 == 0) ? 4'b0001 : 4'b0000, 0, 1, 0);
            tick();
            if (bus_c.o_update_pulse && !prev) begin
                if (last_rise >= 0 && c - last_rise < min_gap) min_gap = c - last_rise;
                last_rise = c;
                rises++;
            end
            if (bus_c.o_update_pulse) run++;
            else begin
                if (prev && run != 1) bad_len++;
                run = 0;
            end
            prev = bus_c.o_update_pulse;
        end
        chk("h3_len", bad_len, 0);
        chk("h3_gap_ge4", int'(min_gap >= 4), 1);
        chk("h3_count_ge10", int'(rises >= 10), 1);

        // Randomized run against the model on all three instances.
        do_reset();
        wr = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            src_pulse = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            if ($urandom_range(0, 7) == 0) wr = ~wr;
            ena = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 19) == 0);
            tick();
            for (int d = 0; d < 3; d++)
                chk($sformatf("rand_dut%0d_cyc%0d", d, c), get_out(d),
                    int'({m_req[d], m_id[d], m_pend[d], m_ovr[d]}));
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
